ysyx_22040632_icache_ctrl: RTL and testbench

YSYX_22040632_ICACHE_CTRL -- requirements
Module: ysyx_22040632_icache_ctrl

---
 rtl/ysyx_22040632_icache_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_ysyx_22040632_icache_ctrl.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040632_icache_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22040632_icache_ctrl
//
// Control FSM for a 2-way set-associative instruction cache with 64-byte lines
// (8 beats of 64 bits), 32 sets. Address split:
// tag=[31:11], index=[10:6], beat=[5:3], word select=[2].
//
// Ports
//   clk, rrst_n        : clock (rising edge), asynchronous active-low reset
//   IFU side           : ifu_valid/ifu_ready/ifu_addr request handshake,
//                        ifu_rvalid/ifu_rready/ifu_rdata response handshake,
//                        fence_i invalidates the whole tag array
//   Tag array          : tag_addr_tag/tag_addr_index lookup address,
//                        tag_wen (active-low) + tag_w_way line install,
//                        tag_fence invalidate-all, hit_1st/hit_2nd per-way
//                        hits, age_1st/age_2nd recency (age_1st=1: way0 MRU)
//   Data array         : dat_ren read (data on dat_rdata next cycle),
//                        dat_wen write, dat_way/dat_index/dat_beat address,
//                        dat_wdata write data
//   Memory read        : single AR burst of 8 beats (mem_arlen=7) and the
//                        R channel (mem_rvalid/mem_rready/mem_rdata)
// ---------------------------------------------------------------------------
module ysyx_22040632_icache_ctrl (
    input  logic        clk,
    input  logic        rrst_n,
    // IFU side
    input  logic        ifu_valid,
    input  logic [31:0] ifu_addr,
    output logic        ifu_ready,
    output logic        ifu_rvalid,
    output logic [31:0] ifu_rdata,
    input  logic        ifu_rready,
    input  logic        fence_i,
    // Tag array side
    output logic [20:0] tag_addr_tag,
    output logic [4:0]  tag_addr_index,
    output logic        tag_wen,
    output logic        tag_w_way,
    output logic        tag_fence,
    input  logic        hit_1st,
    input  logic        hit_2nd,
    input  logic        age_1st,
    input  logic        age_2nd,
    // Data array side
    output logic        dat_ren,
    output logic        dat_wen,
    output logic        dat_way,
    output logic [4:0]  dat_index,
    output logic [2:0]  dat_beat,
    output logic [63:0] dat_wdata,
    input  logic [63:0] dat_rdata,
    // Memory read side
    output logic        mem_arvalid,
    output logic [31:0] mem_araddr,
    output logic [7:0]  mem_arlen,
    input  logic        mem_arready,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    output logic        mem_rready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_AR,
        S_REFILL,
        S_TAGWR,
        S_RESP,
        S_FENCE
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] addr_q;
    logic        victim_q;
    logic [2:0]  beat_q;
    logic        fence_pend_q;
    logic        fence_pend_d;
    logic [31:0] rdata_q;
    logic        resp_first_q;

    logic        lookup_hit;
    logic        accept;
    logic [31:0] word_sel;

    // Byte offset bits and the second age bit carry no information here.
    logic        unused_bits;
    assign unused_bits = &{1'b0, addr_q[1:0], age_2nd};

    assign lookup_hit = hit_1st | hit_2nd;
    assign accept     = (state_q == S_IDLE) && ifu_valid && ifu_ready;
    assign word_sel   = addr_q[2] ? dat_rdata[63:32] : dat_rdata[31:0];

    // Lookup and refill addressing always come from the latched request.
    assign tag_addr_tag   = addr_q[31:11];
    assign tag_addr_index = addr_q[10:6];
    assign dat_index      = addr_q[10:6];
    assign tag_w_way      = victim_q;
    assign dat_wdata      = mem_rdata;
    assign mem_araddr     = {addr_q[31:6], 6'b0};
    assign mem_arlen      = 8'd7;

    // dat_rdata is only valid in the first RESP cycle; pass it straight
    // through then, and serve the captured copy for the rest of RESP.
    assign ifu_rdata = resp_first_q ? word_sel : rdata_q;

    // A fence arriving while busy is remembered and served from IDLE.
    always_comb begin
        fence_pend_d = fence_pend_q;
        if (state_q == S_FENCE) begin
            fence_pend_d = 1'b0;
        end else if (fence_i && (state_q != S_IDLE)) begin
            fence_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            victim_q     <= 1'b0;
            beat_q       <= '0;
            fence_pend_q <= 1'b0;
            rdata_q      <= '0;
            resp_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fence_pend_q <= fence_pend_d;
            resp_first_q <= (state_q == S_LOOKUP) && lookup_hit;
            if (accept) begin
                addr_q <= ifu_addr;
            end
            if ((state_q == S_LOOKUP) && !lookup_hit) begin
                victim_q <= age_1st;
            end
            if (state_q == S_MISS_AR) begin
                beat_q <= '0;
            end else if ((state_q == S_REFILL) && mem_rvalid) begin
                beat_q <= beat_q + 3'd1;
            end
            if (resp_first_q) begin
                rdata_q <= word_sel;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ifu_ready   = 1'b0;
        ifu_rvalid  = 1'b0;
        tag_wen     = 1'b1;
        tag_fence   = 1'b0;
        dat_ren     = 1'b0;
        dat_wen     = 1'b0;
        dat_way     = victim_q;
        dat_beat    = beat_q;
        mem_arvalid = 1'b0;
        mem_rready  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Reset gating keeps ready low while rrst_n is held.
                ifu_ready = rrst_n && !fence_pend_q && !fence_i;
                if (fence_i || fence_pend_q) begin
                    state_d = S_FENCE;
                end else if (ifu_valid && ifu_ready) begin
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (lookup_hit) begin
                    dat_ren  = 1'b1;
                    dat_way  = hit_2nd;
                    dat_beat = addr_q[5:3];
                    state_d  = S_RESP;
                end else begin
                    state_d = S_MISS_AR;
                end
            end
            S_MISS_AR: begin
                mem_arvalid = 1'b1;
                if (mem_arready) begin
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                mem_rready = 1'b1;
                if (mem_rvalid) begin
                    dat_wen = 1'b1;
                    if (beat_q == 3'd7) begin
                        state_d = S_TAGWR;
                    end
                end
            end
            S_TAGWR: begin
                tag_wen = 1'b0;
                state_d = S_LOOKUP;
            end
            S_RESP: begin
                ifu_rvalid = 1'b1;
                if (ifu_rready) begin
                    state_d = S_IDLE;
                end
            end
            S_FENCE: begin
                tag_fence = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_22040632_icache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22040632_icache_ctrl
//
// Bench for the icache controller. Tag/data arrays and an 8-beat burst memory
// are modelled around the DUT; an LRU line-residency model predicts hit/miss.
// ---------------------------------------------------------------------------
module tb_ysyx_22040632_icache_ctrl;

    logic        clk;
    logic        rrst_n;
    logic        ifu_valid;
    logic [31:0] ifu_addr;
    logic        ifu_ready;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic        ifu_rready;
    logic        fence_i;
    logic [20:0] tag_addr_tag;
    logic [4:0]  tag_addr_index;
    logic        tag_wen;
    logic        tag_w_way;
    logic        tag_fence;
    logic        hit_1st;
    logic        hit_2nd;
    logic        age_1st;
    logic        age_2nd;
    logic        dat_ren;
    logic        dat_wen;
    logic        dat_way;
    logic [4:0]  dat_index;
    logic [2:0]  dat_beat;
    logic [63:0] dat_wdata;
    logic [63:0] dat_rdata;
    logic        mem_arvalid;
    logic [31:0] mem_araddr;
    logic [7:0]  mem_arlen;
    logic        mem_arready;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        mem_rready;

    ysyx_22040632_icache_ctrl dut (
        .clk            (clk),
        .rrst_n         (rrst_n),
        .ifu_valid      (ifu_valid),
        .ifu_addr       (ifu_addr),
        .ifu_ready      (ifu_ready),
        .ifu_rvalid     (ifu_rvalid),
        .ifu_rdata      (ifu_rdata),
        .ifu_rready     (ifu_rready),
        .fence_i        (fence_i),
        .tag_addr_tag   (tag_addr_tag),
        .tag_addr_index (tag_addr_index),
        .tag_wen        (tag_wen),
        .tag_w_way      (tag_w_way),
        .tag_fence      (tag_fence),
        .hit_1st        (hit_1st),
        .hit_2nd        (hit_2nd),
        .age_1st        (age_1st),
        .age_2nd        (age_2nd),
        .dat_ren        (dat_ren),
        .dat_wen        (dat_wen),
        .dat_way        (dat_way),
        .dat_index      (dat_index),
        .dat_beat       (dat_beat),
        .dat_wdata      (dat_wdata),
        .dat_rdata      (dat_rdata),
        .mem_arvalid    (mem_arvalid),
        .mem_araddr     (mem_araddr),
        .mem_arlen      (mem_arlen),
        .mem_arready    (mem_arready),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .mem_rready     (mem_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- tag / data array models ----------------
    bit          ev_valid [2][32];
    logic [20:0] ev_tag   [2][32];
    bit          ev_mru   [32];
    logic [63:0] ev_data  [2][32][8];

    assign hit_1st = ev_valid[0][tag_addr_index] && (ev_tag[0][tag_addr_index] == tag_addr_tag);
    assign hit_2nd = ev_valid[1][tag_addr_index] && (ev_tag[1][tag_addr_index] == tag_addr_tag);
    assign age_1st = !ev_mru[tag_addr_index];
    assign age_2nd = ev_mru[tag_addr_index];

    // Main memory contents: a fixed function of the 8-byte aligned address.
    function automatic logic [63:0] mem_fn(input logic [31:0] a);
        return {a ^ 32'h5A5A_0F0F, ~a + 32'h0000_1234};
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [63:0] b;
        b = mem_fn({a[31:3], 3'b000});
        return a[2] ? b[63:32] : b[31:0];
    endfunction

    // ---------------- LRU residency reference ----------------
    int unsigned ref_time = 0;
    int unsigned ref_res [bit [25:0]];

    function automatic bit ref_access(input logic [31:0] a);
        bit [25:0]   line;
        bit [25:0]   old;
        int          n;
        int unsigned oldest;
        line   = a[31:6];
        old    = '0;
        n      = 0;
        oldest = '1;
        ref_time++;
        if (ref_res.exists(line)) begin
            ref_res[line] = ref_time;
            return 1'b1;
        end
        foreach (ref_res[k]) begin
            if (k[4:0] == line[4:0]) begin
                n++;
                if (ref_res[k] < oldest) begin
                    oldest = ref_res[k];
                    old    = k;
                end
            end
        end
        if (n >= 2) ref_res.delete(old);
        ref_res[line] = ref_time;
        return 1'b0;
    endfunction

    // ---------------- memory slave state ----------------
    bit          sl_burst = 1'b0;
    logic [31:0] sl_base  = '0;
    int          sl_beat  = 0;
    int          ar_hold  = 0;
    int          ar_pct   = 100;
    int          r_pct    = 100;

    // ---------------- samples and event counters ----------------
    logic        s_ready, s_rvalid, s_tag_wen, s_tag_w_way, s_tag_fence;
    logic        s_dat_ren, s_dat_wen, s_dat_way, s_arvalid, s_arready, s_rready, s_mrvalid;
    logic [31:0] s_rdata, s_araddr;
    logic [20:0] s_tag;
    logic [4:0]  s_tidx, s_didx;
    logic [2:0]  s_dbeat;
    logic [7:0]  s_arlen;
    logic [63:0] s_wdata;

    int          n_ar = 0, n_wen = 0, n_twen = 0, n_fence = 0, n_ren = 0;
    logic        last_twway = 1'b0, last_wen_way = 1'b0, last_ren_way = 1'b0;
    logic [2:0]  last_ren_beat = '0;
    bit          prev_ar_wait = 1'b0;
    logic [31:0] prev_araddr = '0;

    task automatic tick();
        logic [31:0] off;
        @(negedge clk);
        s_ready = ifu_ready;     s_rvalid = ifu_rvalid;   s_rdata = ifu_rdata;
        s_tag_wen = tag_wen;     s_tag_w_way = tag_w_way; s_tag_fence = tag_fence;
        s_tag = tag_addr_tag;    s_tidx = tag_addr_index;
        s_dat_ren = dat_ren;     s_dat_wen = dat_wen;     s_dat_way = dat_way;
        s_didx = dat_index;      s_dbeat = dat_beat;      s_wdata = dat_wdata;
        s_arvalid = mem_arvalid; s_arready = mem_arready; s_araddr = mem_araddr;
        s_arlen = mem_arlen;     s_rready = mem_rready;   s_mrvalid = mem_rvalid;

        // per-cycle protocol observations
        if (s_arvalid && s_arready) begin
            n_ar++;
            chk("arlen", 64'(s_arlen), 64'd7);
        end
        if (prev_ar_wait) begin
            chk("ar_valid_held", 64'(s_arvalid), 64'd1);
            chk("ar_addr_held", 64'(s_araddr), 64'(prev_araddr));
        end
        prev_ar_wait = s_arvalid && !s_arready;
        prev_araddr  = s_araddr;
        if (s_dat_wen || (s_mrvalid && s_rready)) begin
            chk("wen_on_beat", 64'(s_dat_wen), 64'(s_mrvalid && s_rready));
        end
        if (s_dat_wen) begin
            off = 32'(sl_beat) << 3;
            n_wen++;
            last_wen_way = s_dat_way;
            chk("wdata", s_wdata, mem_fn(sl_base + off));
            chk("wbeat", 64'(s_dbeat), 64'(sl_beat));
            chk("windex", 64'(s_didx), 64'(sl_base[10:6]));
        end
        if (!s_tag_wen) begin
            n_twen++;
            last_twway = s_tag_w_way;
        end
        if (s_tag_fence) n_fence++;
        if (s_dat_ren) begin
            n_ren++;
            last_ren_way  = s_dat_way;
            last_ren_beat = s_dbeat;
        end

        @(posedge clk);
        cyc++;
        #1;
        // array updates for what the DUT did at this edge
        if (!s_tag_wen) begin
            ev_valid[s_tag_w_way][s_tidx] = 1'b1;
            ev_tag[s_tag_w_way][s_tidx]   = s_tag;
            ev_mru[s_tidx]                = s_tag_w_way;
        end
        if (s_tag_fence) begin
            foreach (ev_valid[w, i]) ev_valid[w][i] = 1'b0;
        end
        if (s_dat_wen) ev_data[s_dat_way][s_didx][s_dbeat] = s_wdata;
        if (s_dat_ren) begin
            dat_rdata      = ev_data[s_dat_way][s_didx][s_dbeat];
            ev_mru[s_didx] = s_dat_way;
        end else begin
            dat_rdata = {$urandom, $urandom};
        end
        // memory slave
        if (s_arvalid && s_arready) begin
            sl_burst = 1'b1;
            sl_base  = s_araddr;
            sl_beat  = 0;
        end else if (s_mrvalid && s_rready) begin
            sl_beat++;
            if (sl_beat == 8) sl_burst = 1'b0;
        end
        if (s_arvalid && !s_arready && ar_hold > 0) ar_hold--;
        mem_arready = (ar_hold == 0) && ($urandom_range(99) < ar_pct);
        if (!sl_burst) mem_rvalid = 1'b0;
        else if (!(s_mrvalid && !s_rready)) mem_rvalid = ($urandom_range(99) < r_pct);
        off       = 32'(sl_beat) << 3;
        mem_rdata = sl_burst ? mem_fn(sl_base + off) : {$urandom, $urandom};
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ifu_ready", 64'(s_ready), 64'd0);
        chk("rst_ifu_rvalid", 64'(s_rvalid), 64'd0);
        chk("rst_ifu_rdata", 64'(s_rdata), 64'd0);
        chk("rst_tag_wen", 64'(s_tag_wen), 64'd1);
        chk("rst_tag_fence", 64'(s_tag_fence), 64'd0);
        chk("rst_dat_ren", 64'(s_dat_ren), 64'd0);
        chk("rst_dat_wen", 64'(s_dat_wen), 64'd0);
        chk("rst_arvalid", 64'(s_arvalid), 64'd0);
        chk("rst_rready", 64'(s_rready), 64'd0);
    endtask

    // One complete IFU transaction with response backpressure rr cycles.
    task automatic fetch(input logic [31:0] a, input int ar_h, input int rp, input int rr,
                         input bit exp_hit, input int exp_way, input int fence_beat);
        int  ar0, wen0, tw0, ren0, c_acc, c_rv;
        bit  acc, got, fenced;
        logic [31:0] first;
        ar0 = n_ar; wen0 = n_wen; tw0 = n_twen; ren0 = n_ren;
        acc = 1'b0; got = 1'b0; fenced = 1'b0; c_acc = 0; c_rv = 0;
        ar_hold = ar_h; r_pct = rp;
        ifu_rready = 1'b0;
        ifu_valid  = 1'b1;
        ifu_addr   = a;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (s_ready) begin acc = 1'b1; c_acc = cyc - 1; break; end
        end
        ifu_valid = 1'b0;
        ifu_addr  = $urandom;
        if (!acc) begin
            chk("accept_timeout", 64'd0, 64'd1);
            return;
        end
        for (int i = 0; i < 400; i++) begin
            fence_i = 1'b0;
            if (fence_beat >= 0 && !fenced && (n_wen - wen0) == fence_beat) begin
                fence_i = 1'b1;
                fenced  = 1'b1;
            end
            tick();
            if (s_rvalid) begin got = 1'b1; c_rv = cyc - 1; break; end
        end
        fence_i = 1'b0;
        if (!got) begin
            chk("response_timeout", 64'd0, 64'd1);
            return;
        end
        if (exp_hit) chk("hit_latency", 64'(c_rv - c_acc), 64'd2);
        first = s_rdata;
        chk("rdata", 64'(first), 64'(exp_word(a)));
        for (int k = 0; k < rr; k++) begin
            tick();
            chk("rvalid_held", 64'(s_rvalid), 64'd1);
            chk("rdata_held", 64'(s_rdata), 64'(first));
        end
        ifu_rready = 1'b1;
        tick();
        ifu_rready = 1'b0;
        tick();
        chk("rvalid_dropped", 64'(s_rvalid), 64'd0);
        chk("ar_count", 64'(n_ar - ar0), exp_hit ? 64'd0 : 64'd1);
        chk("wen_count", 64'(n_wen - wen0), exp_hit ? 64'd0 : 64'd8);
        chk("tagwr_count", 64'(n_twen - tw0), exp_hit ? 64'd0 : 64'd1);
        chk("ren_count", 64'(n_ren - ren0), 64'd1);
        chk("ren_beat", 64'(last_ren_beat), 64'(a[5:3]));
        if (exp_way >= 0) begin
            chk("ren_way", 64'(last_ren_way), 64'(exp_way));
            if (!exp_hit) begin
                chk("tag_w_way", 64'(last_twway), 64'(exp_way));
                chk("wen_way", 64'(last_wen_way), 64'(exp_way));
            end
        end
    endtask

    // Fence raised in IDLE, optionally together with a request.
    task automatic fence_idle(input bit with_valid);
        int ar0;
        ar0 = n_ar;
        ifu_valid = with_valid;
        ifu_addr  = 32'h8000_0040;
        fence_i   = 1'b1;
        tick();
        chk("fence_blocks_ready", 64'(s_ready), 64'd0);
        fence_i   = 1'b0;
        ifu_valid = 1'b0;
        tick();
        chk("fence_pulse", 64'(s_tag_fence), 64'd1);
        tick();
        chk("fence_single", 64'(s_tag_fence), 64'd0);
        chk("ready_after_fence", 64'(s_ready), 64'd1);
        chk("fence_no_ar", 64'(n_ar - ar0), 64'd0);
        ref_res.delete();
    endtask

    typedef struct {
        logic [31:0] addr;
        int          ar_h;
        int          rp;
        int          rr;
        bit          miss;
        int          way;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #500_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, tw0, w0;
        bit ok, h;
        logic [31:0] a;

        vecs[0] = '{32'h8000_0040, 0, 100, 0, 1'b1, 0};
        vecs[1] = '{32'h8000_0044, 0, 100, 0, 1'b0, 0};
        vecs[2] = '{32'h8000_0840, 5,  60, 3, 1'b1, 1};
        vecs[3] = '{32'h8000_0040, 0, 100, 1, 1'b0, 0};
        vecs[4] = '{32'h8000_1040, 1,  70, 0, 1'b1, 1};
        vecs[5] = '{32'h8000_0048, 0, 100, 2, 1'b0, 0};
        vecs[6] = '{32'h8000_0840, 0,  80, 0, 1'b1, 1};
        vecs[7] = '{32'h8000_107C, 2,  50, 0, 1'b1, 0};
        vecs[8] = '{32'h8000_0878, 0, 100, 0, 1'b0, 1};

        foreach (ev_valid[w, i]) begin
            ev_valid[w][i] = 1'b0;
            ev_tag[w][i]   = '0;
        end
        foreach (ev_mru[i]) ev_mru[i] = 1'b1;
        foreach (ev_data[w, i, b]) ev_data[w][i][b] = '0;

        rrst_n = 1'b0; ifu_valid = 1'b0; ifu_addr = '0; ifu_rready = 1'b0; fence_i = 1'b0;
        dat_rdata = '0; mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick();
        chk_reset_outputs();
        tick();
        chk_reset_outputs();
        rrst_n = 1'b1;
        tick();
        chk("ready_after_release", 64'(s_ready), 64'd1);

        // table-driven fills, hits and replacement
        for (int i = 0; i < 9; i++) begin
            h = ref_access(vecs[i].addr);
            fetch(vecs[i].addr, vecs[i].ar_h, vecs[i].rp, vecs[i].rr, !vecs[i].miss, vecs[i].way, -1);
        end

        // fence during refill: serviced after the response, before next ready
        f0 = n_fence;
        h  = ref_access(32'h8000_2080);
        fetch(32'h8000_2080, 0, 100, 0, h, 0, 3);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_ready) begin ok = 1'b1; break; end
        end
        chk("ready_after_pending_fence", 64'(ok), 64'd1);
        chk("pending_fence_pulses", 64'(n_fence - f0), 64'd1);
        ref_res.delete();
        h = ref_access(32'h8000_2084);
        fetch(32'h8000_2084, 0, 100, 0, h, 1, -1);

        // fence and request together in IDLE
        fence_idle(1'b1);

        // reset on the 4th refill beat
        tw0 = n_twen;
        w0  = n_wen;
        r_pct = 100; ar_hold = 0;
        ifu_valid = 1'b1;
        ifu_addr  = 32'h8000_30C0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (s_ready) begin ok = 1'b1; break; end
        end
        ifu_valid = 1'b0;
        chk("abort_accept", 64'(ok), 64'd1);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if ((n_wen - w0) >= 4) begin ok = 1'b1; break; end
            tick();
        end
        chk("abort_reached_beat4", 64'(ok), 64'd1);
        rrst_n = 1'b0;
        tick();
        chk_reset_outputs();
        tick();
        chk_reset_outputs();
        rrst_n = 1'b1;
        tick();
        chk("ready_after_midburst_reset", 64'(s_ready), 64'd1);
        chk("rready_after_midburst_reset", 64'(s_rready), 64'd0);
        tick();
        tick();
        chk("abort_no_tagwr", 64'(n_twen - tw0), 64'd0);
        chk("abort_four_writes", 64'(n_wen - w0), 64'd4);
        sl_burst   = 1'b0;
        mem_rvalid = 1'b0;
        tick();
        h = ref_access(32'h8000_30C0);
        fetch(32'h8000_30C0, 0, 100, 0, h, 0, -1);

        // randomized traffic over a few conflicting sets
        ar_pct = 60;
        for (int n = 0; n < 40; n++) begin
            logic [20:0] tg;
            logic [4:0]  ix;
            logic [5:0]  of;
            tg = 21'h10_0000 + 21'($urandom_range(0, 3));
            ix = 5'($urandom_range(0, 3));
            of = 6'($urandom_range(0, 15) * 4);
            a  = {tg, ix, of};
            if ($urandom_range(0, 7) == 0) fence_idle(1'($urandom_range(0, 1)));
            h = ref_access(a);
            fetch(a, $urandom_range(0, 2), $urandom_range(40, 100), $urandom_range(0, 2), h, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
